// File: rtl/pci_fifo_arbiter.sv
// pci_fifo_arbiter: first-come-first-served PCI arbiter with an in-order request queue.
// Optional macro ARB_TIMEOUT_EN revokes a grant whose master never asserts FRAME within TIMEOUT cycles.
module pci_fifo_arbiter #(
    parameter int N_MASTERS = 8,
    parameter int TIMEOUT = 16,
    localparam int IDXW = $clog2(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] REQ,
    input  logic                 GLOBAL_FRAME,
    input  logic                 GLOBAL_IRDY,
    output logic [N_MASTERS-1:0] GNT,
    output logic [IDXW-1:0]      OWNER,
    output logic                 BUS_BUSY,
    output logic [IDXW:0]        QCOUNT
);
    typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

    if (N_MASTERS < 2 || N_MASTERS > 32 || TIMEOUT < 1) begin : g_param_check
        $error("pci_fifo_arbiter: unsupported N_MASTERS or TIMEOUT");
    end

    state_t               state, state_n;
    logic [IDXW-1:0]      q [N_MASTERS];
    logic [IDXW-1:0]      q_n [N_MASTERS];
    logic [IDXW-1:0]      head, tail, head_n, tail_n, hd, owner_n;
    logic [N_MASTERS-1:0] pending, pending_n, prev_req, gnt_n;
    logic [IDXW:0]        cnt_n;
    logic                 busy_n, bus_idle, repush, timed_out;

    function automatic logic [IDXW-1:0] inc(input logic [IDXW-1:0] p);
        return (p == IDXW'(N_MASTERS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign bus_idle = GLOBAL_FRAME & GLOBAL_IRDY;
    assign hd = q[head];

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    // Held at zero outside GRANT, so every grant starts a fresh count.
    always_ff @(posedge clk or posedge rst)
        if (rst) tcnt <= '0;
        else tcnt <= (state == GRANT) ? tcnt + 1'b1 : '0;
    assign timed_out = (state == GRANT) && (tcnt == TW'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        q_n       = q;
        head_n    = head;
        tail_n    = tail;
        pending_n = pending;
        cnt_n     = QCOUNT;
        gnt_n     = GNT;
        owner_n   = OWNER;
        busy_n    = BUS_BUSY;
        repush    = 1'b0;
        for (int i = 0; i < N_MASTERS; i++)
            if (REQ[i] && !prev_req[i]) pending_n[i] = 1'b0;
        case (state)
            IDLE: if (QCOUNT != '0) begin
                if (!pending[hd]) begin
                    head_n = inc(head);
                    cnt_n  = cnt_n - 1'b1;
                end else if (bus_idle) begin
                    head_n        = inc(head);
                    cnt_n         = cnt_n - 1'b1;
                    gnt_n         = '1;
                    gnt_n[hd]     = 1'b0;
                    owner_n       = hd;
                    pending_n[hd] = 1'b0;
                    state_n       = GRANT;
                end
            end
            GRANT: if (!GLOBAL_FRAME) begin
                gnt_n   = '1;
                busy_n  = 1'b1;
                state_n = BUSY;
            end else if (REQ[OWNER]) begin
                gnt_n   = '1;
                state_n = IDLE;
            end else if (timed_out) begin
                gnt_n   = '1;
                state_n = IDLE;
                repush  = 1'b1;
            end
            BUSY: if (bus_idle) begin
                busy_n  = 1'b0;
                state_n = IDLE;
                repush  = !REQ[OWNER];
            end
            default: state_n = IDLE;
        endcase
        // New requests enter in ascending index order, ahead of any re-queued owner.
        for (int i = 0; i < N_MASTERS; i++)
            if (!REQ[i] && prev_req[i] && !pending[i] && cnt_n < (IDXW+1)'(N_MASTERS)) begin
                q_n[tail_n]  = IDXW'(i);
                tail_n       = inc(tail_n);
                cnt_n        = cnt_n + 1'b1;
                pending_n[i] = 1'b1;
            end
        if (repush && !pending_n[OWNER] && cnt_n < (IDXW+1)'(N_MASTERS)) begin
            q_n[tail_n]      = OWNER;
            tail_n           = inc(tail_n);
            cnt_n            = cnt_n + 1'b1;
            pending_n[OWNER] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            head     <= '0;
            tail     <= '0;
            pending  <= '0;
            prev_req <= '1;
            GNT      <= '1;
            OWNER    <= '0;
            BUS_BUSY <= 1'b0;
            QCOUNT   <= '0;
            for (int i = 0; i < N_MASTERS; i++) q[i] <= '0;
        end else begin
            state    <= state_n;
            head     <= head_n;
            tail     <= tail_n;
            pending  <= pending_n;
            prev_req <= REQ;
            GNT      <= gnt_n;
            OWNER    <= owner_n;
            BUS_BUSY <= busy_n;
            QCOUNT   <= cnt_n;
            q        <= q_n;
        end
    end
endmodule

// File: tb/tb_pci_fifo_arbiter.sv
// tb_pci_fifo_arbiter: directed and random checks of pci_fifo_arbiter against a queue-based model.
module tb_pci_fifo_arbiter;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst, frame, irdy, busy;
    logic [7:0] req, gnt;
    logic [2:0] owner;
    logic [3:0] qcount;
    int         tests = 0, fails = 0;

    int         m_q[$];
    logic [7:0] m_pend, m_prev, m_gnt;
    int         m_own, m_ph, m_wait;
    logic       m_busy;

    always #5 clk = ~clk;

    pci_fifo_arbiter #(.N_MASTERS(8), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .REQ(req), .GLOBAL_FRAME(frame), .GLOBAL_IRDY(irdy),
        .GNT(gnt), .OWNER(owner), .BUS_BUSY(busy), .QCOUNT(qcount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pend = '0; m_prev = '1; m_gnt = '1;
        m_own = 0; m_ph = 0; m_wait = 0; m_busy = 1'b0;
    endtask

    // ph: 0 = waiting to grant, 1 = granted, 2 = transaction on the bus
    task automatic model_step();
        logic       idle = frame && irdy;
        logic [7:0] np = m_pend;
        logic       rq = 1'b0;
        int         h;
        for (int i = 0; i < 8; i++) if (req[i] && !m_prev[i]) np[i] = 1'b0;
        if (m_ph == 0 && m_q.size() > 0) begin
            h = m_q[0];
            if (!m_pend[h]) void'(m_q.pop_front());
            else if (idle) begin
                void'(m_q.pop_front());
                m_gnt = ~(8'b1 << h); m_own = h; np[h] = 1'b0; m_ph = 1; m_wait = 0;
            end
        end else if (m_ph == 1) begin
            if (!frame) begin m_gnt = '1; m_busy = 1'b1; m_ph = 2; end
            else if (req[m_own]) begin m_gnt = '1; m_ph = 0; end
            else begin
                m_wait++;
`ifdef ARB_TIMEOUT_EN
                if (m_wait == TIMEOUT) begin m_gnt = '1; m_ph = 0; rq = 1'b1; end
`endif
            end
        end else if (m_ph == 2 && idle) begin
            m_busy = 1'b0; m_ph = 0; rq = !req[m_own];
        end
        for (int i = 0; i < 8; i++)
            if (!req[i] && m_prev[i] && !m_pend[i]) begin m_q.push_back(i); np[i] = 1'b1; end
        if (rq && !np[m_own]) begin m_q.push_back(m_own); np[m_own] = 1'b1; end
        m_pend = np;
        m_prev = req;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk); #1;
        chk("gnt", gnt, m_gnt);
        chk("owner", owner, m_own);
        chk("bus_busy", busy, m_busy);
        chk("qcount", qcount, m_q.size());
        chk("gnt_onehot0", $countones(~gnt) <= 1, 1);
    endtask

    // Waits for a grant, checks the owner, then runs a one-cycle transaction.
    task automatic serve(input int exp_owner, input logic keep, output int n);
        n = 0;
        while (gnt === 8'hFF && n < 20) begin cycle(); n++; end
        chk("serve_granted", gnt !== 8'hFF, 1);
        chk("serve_owner", owner, exp_owner);
        if (!keep) req[exp_owner] = 1'b1;
        frame = 1'b0; irdy = 1'b0;
        cycle();
        frame = 1'b1; irdy = 1'b1;
        cycle();
    endtask

    task automatic rand_inputs();
        logic [7:0] nr = req;
        int         room = 7 - m_q.size();
        for (int i = 0; i < 8; i++)
            if ($urandom_range(0, 7) == 0) begin
                if (nr[i] && !m_pend[i]) begin
                    if (room > 0) begin nr[i] = 1'b0; room--; end
                end else nr[i] = ~nr[i];
            end
        req   = nr;
        frame = ($urandom_range(0, 3) != 0);
        irdy  = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; req = '1; frame = 1'b1; irdy = 1'b1;
        model_reset();
        @(posedge clk); #1;
        chk("rst_gnt", gnt, 8'hFF);
        chk("rst_owner", owner, 0);
        chk("rst_busy", busy, 0);
        chk("rst_qcount", qcount, 0);
        rst = 1'b0;

        req = 8'hFB;
        cycle();
        chk("t1_qcount", qcount, 1);
        cycle();
        chk("t1_gnt", gnt, 8'hFB);
        chk("t1_owner", owner, 2);
        frame = 1'b0;
        cycle();
        chk("t1_busy_gnt", gnt, 8'hFF);
        chk("t1_busy", busy, 1);
        frame = 1'b1; req = 8'hFF;
        cycle();
        chk("t1_idle", busy, 0);

        req = 8'hDA;
        cycle();
        chk("t2_qcount", qcount, 3);
        serve(0, 1'b0, n);
        serve(2, 1'b0, n);
        chk("t2_gap2", n, 1);
        serve(5, 1'b0, n);
        chk("t2_gap5", n, 1);

        req[1] = 1'b0; cycle(); cycle();
        chk("t3_owner1", owner, 1);
        frame = 1'b0; irdy = 1'b0; cycle();
        req[3] = 1'b0; cycle();
        req[6] = 1'b0; cycle();
        req[3] = 1'b1; cycle();
        req[1] = 1'b1; frame = 1'b1; irdy = 1'b1; cycle();
        chk("t3_q2", qcount, 2);
        cycle();
        chk("t3_skip_q", qcount, 1);
        chk("t3_skip_gnt", gnt, 8'hFF);
        cycle();
        chk("t3_gnt6", gnt, 8'hBF);
        serve(6, 1'b0, n);

        req[4] = 1'b0; cycle(); cycle();
        chk("t4_gnt4", gnt, 8'hEF);
        req[6] = 1'b0; frame = 1'b0; irdy = 1'b0; cycle();
        frame = 1'b1; irdy = 1'b1; cycle();
        chk("t4_requeue_q", qcount, 2);
        serve(6, 1'b0, n);
        serve(4, 1'b0, n);

        req[7] = 1'b0; cycle(); cycle();
        chk("t5_gnt7", gnt, 8'h7F);
`ifdef ARB_TIMEOUT_EN
        n = 0;
        while (gnt !== 8'hFF && n < 40) begin cycle(); n++; end
        chk("t5_timeout_len", n, TIMEOUT);
        chk("t5_requeued", qcount, 1);
`else
        repeat (30) cycle();
        chk("t5_held", gnt, 8'h7F);
`endif
        req[7] = 1'b1;
        repeat (3) cycle();
        chk("t5_release", gnt, 8'hFF);

        req[1] = 1'b0; cycle(); cycle();
        frame = 1'b0; irdy = 1'b0; cycle();
        req[2] = 1'b0; req[3] = 1'b0; req[5] = 1'b0; cycle();
        chk("t6_pre_q", qcount, 3);
        chk("t6_pre_busy", busy, 1);
        rst = 1'b1; #1;
        chk("t6_async_gnt", gnt, 8'hFF);
        chk("t6_async_q", qcount, 0);
        chk("t6_async_busy", busy, 0);
        req = '1; frame = 1'b1; irdy = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        repeat (800) begin rand_inputs(); cycle(); end
        req = '1; frame = 1'b1; irdy = 1'b1;
        repeat (20) cycle();
        chk("drain_q", qcount, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
